// File: rtl/psum_pkg.sv
// psum_pkg
// Shared definitions for the partial-sum writer: FSM state encoding, default
// sizing constants and a counter-width helper.
// No ports (package).
package psum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } psum_state_e;

  localparam int PSUM_BW_DEF  = 16;
  localparam int COL_DEF      = 8;
  localparam int LEN_KIJ_DEF  = 9;
  localparam int LEN_ONIJ_DEF = 16;
  localparam int ADDR_BW_DEF  = 11;

  // Width of a counter that must be able to hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/psum_addr_gen.sv
// psum_addr_gen
// Holds the pass base address and the read/write row counters, and owns the
// registered SRAM address. Base is latched as kij*len_onij on load.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load, kij   : start of an accepted pass and its kernel index
//   rd_inc      : one row popped from the output FIFO this cycle
//   wr_en       : one row written to SRAM this cycle (address registered)
//   rd_cnt      : rows popped so far in this pass
//   wr_cnt      : rows written so far in this pass
//   sram_addr   : registered SRAM address (holds when no write)
module psum_addr_gen
  import psum_pkg::*;
#(
  parameter int len_onij = LEN_ONIJ_DEF,
  parameter int addr_bw  = ADDR_BW_DEF,
  parameter int cnt_w    = cnt_width(len_onij)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [3:0]         kij,
  input  logic               rd_inc,
  input  logic               wr_en,
  output logic [cnt_w-1:0]   rd_cnt,
  output logic [cnt_w-1:0]   wr_cnt,
  output logic [addr_bw-1:0] sram_addr
);

  logic [addr_bw-1:0] base_q, base_d;
  logic [addr_bw-1:0] sram_addr_q, sram_addr_d;
  logic [cnt_w-1:0]   rd_cnt_q, rd_cnt_d;
  logic [cnt_w-1:0]   wr_cnt_q, wr_cnt_d;

  always_comb begin
    base_d      = base_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    sram_addr_d = sram_addr_q;
    if (load) begin
      // Product wraps modulo 2^addr_bw by construction of the operand widths.
      base_d   = addr_bw'(kij) * addr_bw'(len_onij);
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (rd_inc) begin
        rd_cnt_d = rd_cnt_q + cnt_w'(1);
      end
      if (wr_en) begin
        sram_addr_d = base_q + addr_bw'(wr_cnt_q);
        wr_cnt_d    = wr_cnt_q + cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      sram_addr_q <= '0;
    end else begin
      base_q      <= base_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      sram_addr_q <= sram_addr_d;
    end
  end

  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign sram_addr = sram_addr_q;

endmodule

// File: rtl/psum_writer.sv
// psum_writer
// Drains len_onij rows of column partial sums from the output FIFO into the
// psum SRAM for one kernel position (kij), at base address kij*len_onij.
// Optional build macro: PSUM_WR_PERF_EN adds the stall_cnt output.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start, kij  : one-cycle pass request and its kernel index
//   o_valid     : output FIFO holds at least one row
//   ofifo_data  : FIFO read data, valid the cycle after ofifo_rd
//   ofifo_rd    : registered FIFO pop strobe
//   sram_*      : registered SRAM controls (cen/wen active-low), addr, data
//   busy, done  : pass in progress / one-cycle completion pulse
//   stall_cnt   : (PSUM_WR_PERF_EN) DRAIN cycles spent with o_valid low
//   err         : one-cycle pulse for a start with out-of-range kij
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; rejects kij >= len_kij with err
// ST_DRAIN | popping rows while o_valid and rd_cnt < len_onij
// ST_FLUSH | all rows popped; waiting for in-flight writes to land
// ST_DONE  | pulses done, returns to idle
module psum_writer
  import psum_pkg::*;
#(
  parameter int psum_bw  = PSUM_BW_DEF,
  parameter int col      = COL_DEF,
  parameter int len_kij  = LEN_KIJ_DEF,
  parameter int len_onij = LEN_ONIJ_DEF,
  parameter int addr_bw  = ADDR_BW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             kij,
  input  logic                   o_valid,
  input  logic [col*psum_bw-1:0] ofifo_data,
  output logic                   ofifo_rd,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic [addr_bw-1:0]     sram_addr,
  output logic [col*psum_bw-1:0] sram_din,
  output logic                   busy,
  output logic                   done,
`ifdef PSUM_WR_PERF_EN
  output logic [15:0]            stall_cnt,
`endif
  output logic                   err
);

  localparam int CNT_W = cnt_width(len_onij);
  localparam int DW    = col * psum_bw;

  psum_state_e state_q, state_d;

  logic          ofifo_rd_q, ofifo_rd_d;
  logic          wr_pend_q, wr_pend_d;
  logic          sram_cen_q, sram_cen_d;
  logic          sram_wen_q, sram_wen_d;
  logic [DW-1:0] sram_din_q, sram_din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic             kij_ok, start_ok, start_bad;
  logic             rd_more, rd_inc, wr_en;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  always_comb begin
    kij_ok    = {28'd0, kij} < 32'(len_kij);
    start_ok  = (state_q == ST_IDLE) && start && kij_ok;
    start_bad = (state_q == ST_IDLE) && start && !kij_ok;
    rd_more   = rd_cnt < CNT_W'(len_onij);
    rd_inc    = (state_q == ST_DRAIN) && o_valid && rd_more;
    // The pop issued last cycle returns its data this cycle.
    wr_en     = wr_pend_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_DRAIN;
      ST_DRAIN: if (!rd_more) state_d = ST_FLUSH;
      ST_FLUSH: if (wr_cnt == CNT_W'(len_onij)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // The pop decision is made on this cycle's o_valid and presented to the
    // FIFO from the flop on the next cycle.
    ofifo_rd_d = rd_inc;
    wr_pend_d  = ofifo_rd_q;
    sram_cen_d = !wr_en;
    sram_wen_d = !wr_en;
    sram_din_d = wr_en ? ofifo_data : sram_din_q;
    busy_d     = (state_d == ST_DRAIN) || (state_d == ST_FLUSH);
    done_d     = (state_d == ST_DONE);
    err_d      = start_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ofifo_rd_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      sram_cen_q <= 1'b1;
      sram_wen_q <= 1'b1;
      sram_din_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ofifo_rd_q <= ofifo_rd_d;
      wr_pend_q  <= wr_pend_d;
      sram_cen_q <= sram_cen_d;
      sram_wen_q <= sram_wen_d;
      sram_din_q <= sram_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  psum_addr_gen #(
    .len_onij (len_onij),
    .addr_bw  (addr_bw),
    .cnt_w    (CNT_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok),
    .kij       (kij),
    .rd_inc    (rd_inc),
    .wr_en     (wr_en),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .sram_addr (sram_addr)
  );

`ifdef PSUM_WR_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q == ST_DRAIN) && !o_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign ofifo_rd = ofifo_rd_q;
  assign sram_cen = sram_cen_q;
  assign sram_wen = sram_wen_q;
  assign sram_din = sram_din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_psum_writer.sv
// tb_psum_writer
// Self-checking bench for psum_writer with default parameters. A small FIFO
// model answers each pop with random data the following cycle and pushes the
// expected SRAM write onto a scoreboard; observed writes are logged and each
// scenario task compares them against the scoreboard.
module tb_psum_writer;

  localparam int AW       = 11;
  localparam int DW       = 128;
  localparam int LEN_ONIJ = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
    logic          wen;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    kij;
  logic          o_valid;
  logic [DW-1:0] ofifo_data;
  logic          ofifo_rd;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic          busy;
  logic          done;
  logic          err;
`ifdef PSUM_WR_PERF_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   stall_at_done;
`endif

  psum_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .kij        (kij),
    .o_valid    (o_valid),
    .ofifo_data (ofifo_data),
    .ofifo_rd   (ofifo_rd),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .busy       (busy),
    .done       (done),
`ifdef PSUM_WR_PERF_EN
    .stall_cnt  (stall_cnt),
`endif
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  pend = 1'b0;
  int  base_exp = 0;
  int  pop_idx = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  err_cnt = 0;
  int  busy_cnt = 0;
  wr_t sb[$];
  wr_t obs[$];
  int  pops[$];

  // One clock: FIFO model plus observation log. Outputs are sampled on the
  // falling edge; inputs are changed by callers right after it returns.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pend) begin
      ofifo_data = {$urandom, $urandom, $urandom, $urandom};
      sb.push_back('{AW'(base_exp + pop_idx), ofifo_data, 32'(cyc + 1), 1'b0});
      pop_idx++;
    end
    pend = ofifo_rd;
    if (ofifo_rd === 1'b1) pops.push_back(cyc);
    if (sram_cen === 1'b0) obs.push_back('{sram_addr, sram_din, 32'(cyc), sram_wen});
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef PSUM_WR_PERF_EN
      stall_at_done = stall_cnt;
`endif
    end
    if (err === 1'b1) err_cnt++;
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic clear_log();
    sb.delete();
    obs.delete();
    pops.delete();
    done_cnt = 0;
    done_cyc = -1;
    err_cnt  = 0;
    busy_cnt = 0;
    pop_idx  = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; kij = 4'd0; o_valid = 1'b0; ofifo_data = '0;
    tick();
    tick();
    checks++;
    if ({ofifo_rd, sram_cen, sram_wen, busy, done, err} !== 6'b011000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 011000",
               {ofifo_rd, sram_cen, sram_wen, busy, done, err});
    end
    checks++;
    if (sram_addr !== '0 || sram_din !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%0d din=%h expected 0/0", sram_addr, sram_din);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || sram_cen !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: got busy=%b cen=%b expected 0/1", busy, sram_cen);
    end
  endtask

  // Mode 0: o_valid held high. 1: toggling. 2: low for 5 DRAIN cycles.
  // 3: held high with a second start (kij=5) while busy.
  task automatic test_passes();
    logic [3:0] kv [5];
    int         md [5];
    kv = '{4'd2, 4'd0, 4'd3, 4'd4, 4'd8};
    md = '{0, 1, 2, 3, 0};
    for (int p = 0; p < 5; p++) begin
      int  start_cyc;
      int  extra;
      int  last;
      wr_t e;
      clear_log();
      base_exp = int'(kv[p]) * LEN_ONIJ;
      o_valid = 1'b1; start = 1'b1; kij = kv[p];
      tick();
      start = 1'b0;
      start_cyc = cyc;
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_start kij=%0d: got %b expected 1", kv[p], busy);
      end
      extra = 0;
      for (int i = 1; i < 120 && extra < 3; i++) begin
        case (md[p])
          1:       o_valid = (i % 2 == 0);
          2:       o_valid = !(i >= 3 && i < 8);
          default: o_valid = 1'b1;
        endcase
        if (md[p] == 3 && i == 3) begin
          start = 1'b1;
          kij   = 4'd5;
        end
        tick();
        start = 1'b0;
        if (done_cnt > 0) extra++;
      end
      o_valid = 1'b0;
      checks++;
      if (pops.size() != LEN_ONIJ) begin
        failures++;
        $display("FAIL pop_count kij=%0d: got %0d expected %0d", kv[p], pops.size(), LEN_ONIJ);
      end
      checks++;
      if (obs.size() != LEN_ONIJ) begin
        failures++;
        $display("FAIL wr_count kij=%0d: got %0d expected %0d", kv[p], obs.size(), LEN_ONIJ);
      end
      foreach (obs[j]) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected kij=%0d: got addr=%0d with no expected write", kv[p], obs[j].addr);
        end else begin
          e = sb.pop_front();
          if (obs[j] !== e) begin
            failures++;
            $display("FAIL wr kij=%0d: got addr=%0d cyc=%0d wen=%b din=%h expected addr=%0d cyc=%0d wen=%b din=%h",
                     kv[p], obs[j].addr, obs[j].cyc, obs[j].wen, obs[j].data,
                     e.addr, e.cyc, e.wen, e.data);
          end
        end
      end
      checks++;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL wr_missing kij=%0d: got %0d writes outstanding expected 0", kv[p], sb.size());
      end
      checks++;
      if (done_cnt != 1) begin
        failures++;
        $display("FAIL done_count kij=%0d: got %0d expected 1", kv[p], done_cnt);
      end
      last = (obs.size() > 0) ? int'(obs[obs.size()-1].cyc) : -100;
      checks++;
      if (done_cyc != last + 1) begin
        failures++;
        $display("FAIL done_timing kij=%0d: got cycle %0d expected %0d", kv[p], done_cyc, last + 1);
      end
      checks++;
      if (busy_cnt != done_cyc - start_cyc) begin
        failures++;
        $display("FAIL busy_len kij=%0d: got %0d expected %0d", kv[p], busy_cnt, done_cyc - start_cyc);
      end
      checks++;
      if (err_cnt != 0) begin
        failures++;
        $display("FAIL err_spurious kij=%0d: got %0d expected 0", kv[p], err_cnt);
      end
      if (md[p] == 0) begin
        checks++;
        if (pops.size() != LEN_ONIJ || pops[0] != start_cyc + 1 || pops[LEN_ONIJ-1] != pops[0] + LEN_ONIJ - 1) begin
          failures++;
          $display("FAIL pop_timing kij=%0d: got first=%0d n=%0d expected first=%0d consecutive",
                   kv[p], (pops.size() > 0) ? pops[0] : -1, pops.size(), start_cyc + 1);
        end
      end
`ifdef PSUM_WR_PERF_EN
      if (md[p] == 2) begin
        checks++;
        if (stall_at_done !== 16'd5) begin
          failures++;
          $display("FAIL stall_cnt: got %0d expected 5", stall_at_done);
        end
      end
`endif
      if (obs.size() > 0) begin
        checks++;
        if (sram_addr !== obs[obs.size()-1].addr || sram_din !== obs[obs.size()-1].data || sram_cen !== 1'b1) begin
          failures++;
          $display("FAIL idle_hold kij=%0d: got addr=%0d cen=%b expected addr=%0d cen=1",
                   kv[p], sram_addr, sram_cen, obs[obs.size()-1].addr);
        end
      end
    end
  endtask

  task automatic test_bad_kij();
    logic [3:0] kv [2];
    kv = '{4'd9, 4'd15};
    for (int p = 0; p < 2; p++) begin
      clear_log();
      o_valid = 1'b1; start = 1'b1; kij = kv[p];
      tick();
      start = 1'b0;
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL err_pulse kij=%0d: got %b expected 1", kv[p], err);
      end
      for (int i = 0; i < 5; i++) tick();
      o_valid = 1'b0;
      checks++;
      if (err_cnt != 1 || busy_cnt != 0) begin
        failures++;
        $display("FAIL err_once kij=%0d: got err_cycles=%0d busy_cycles=%0d expected 1/0", kv[p], err_cnt, busy_cnt);
      end
      checks++;
      if (obs.size() != 0 || pops.size() != 0) begin
        failures++;
        $display("FAIL err_no_access kij=%0d: got writes=%0d pops=%0d expected 0/0", kv[p], obs.size(), pops.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    int  rst_cyc;
    int  n_after;
    wr_t e;
    clear_log();
    base_exp = 1 * LEN_ONIJ;
    o_valid = 1'b1; start = 1'b1; kij = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && pops.size() < 7; i++) tick();
    checks++;
    if (pops.size() != 7) begin
      failures++;
      $display("FAIL rst_mid_reach: got %0d pops expected 7", pops.size());
    end
    reset = 1'b1;
    tick();
    rst_cyc = cyc;
    checks++;
    if ({ofifo_rd, sram_cen, sram_wen, busy, done, err} !== 6'b011000 || sram_addr !== '0 || sram_din !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got ctrl=%b addr=%0d expected ctrl=011000 addr=0",
               {ofifo_rd, sram_cen, sram_wen, busy, done, err}, sram_addr);
    end
    reset = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    o_valid = 1'b0;
    n_after = 0;
    foreach (obs[j]) if (int'(obs[j].cyc) >= rst_cyc) n_after++;
    checks++;
    if (n_after != 0) begin
      failures++;
      $display("FAIL rst_mid_no_write: got %0d writes after reset expected 0", n_after);
    end
    checks++;
    if (obs.size() != 5 || pops.size() != 7) begin
      failures++;
      $display("FAIL rst_mid_counts: got writes=%0d pops=%0d expected 5/7", obs.size(), pops.size());
    end
    foreach (obs[j]) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rst_mid_wr_unexpected: got addr=%0d with no expected write", obs[j].addr);
      end else begin
        e = sb.pop_front();
        if (obs[j] !== e) begin
          failures++;
          $display("FAIL rst_mid_wr: got addr=%0d cyc=%0d expected addr=%0d cyc=%0d",
                   obs[j].addr, obs[j].cyc, e.addr, e.cyc);
        end
      end
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL rst_mid_done: got %0d done pulses expected 0", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_passes();
    test_bad_kij();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
